// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: operand classes, flag positions
// and width-generic constructors for the special encodings.
package fp_pkg;

   localparam int unsigned DefExpW = 8;
   localparam int unsigned DefManW = 23;

   // Constructors build into a wide vector; callers truncate to their own word width.
   localparam int unsigned MaxW = 64;

   typedef enum logic [1:0] {
      ClsZero,
      ClsNorm,
      ClsInf,
      ClsNan
   } fp_class_e;

   localparam int unsigned FlagInvalid   = 3;
   localparam int unsigned FlagOverflow  = 2;
   localparam int unsigned FlagUnderflow = 1;
   localparam int unsigned FlagInexact   = 0;

   function automatic int unsigned fp_bias(int unsigned exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic logic [MaxW-1:0] fp_inf(int unsigned exp_w, int unsigned man_w, logic sign);
      logic [MaxW-1:0] r;
      r = ((MaxW'(1) << exp_w) - MaxW'(1)) << man_w;
      r = r | (MaxW'(sign) << (exp_w + man_w));
      return r;
   endfunction

   function automatic logic [MaxW-1:0] fp_qnan(int unsigned exp_w, int unsigned man_w);
      return fp_inf(exp_w, man_w, 1'b0) | (MaxW'(1) << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe; master is the issuing/consuming side.
interface fp_mult_pipe_if import fp_pkg::*; #(
   parameter int unsigned EXP_W = DefExpW,
   parameter int unsigned MAN_W = DefManW
);

   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, out, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, out, flags
   );

endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE operand into fields and classifies it; subnormals are treated as zero.
module fp_unpack import fp_pkg::*; #(
   parameter int unsigned EXP_W = DefExpW,
   parameter int unsigned MAN_W = DefManW
) (
   input  logic [EXP_W+MAN_W:0] op,
   output logic                 sign,
   output logic [EXP_W-1:0]     bexp,
   output logic [MAN_W:0]       sig,
   output fp_class_e            cls
);

   logic [MAN_W-1:0] man;

   assign sign = op[EXP_W+MAN_W];
   assign bexp = op[MAN_W +: EXP_W];
   assign man  = op[MAN_W-1:0];
   assign sig  = {1'b1, man};

   always_comb begin
      cls = ClsNorm;
      if (bexp == '0) begin
         cls = ClsZero;
      end else if (&bexp) begin
         cls = (man == '0) ? ClsInf : ClsNan;
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier (unpack, multiply, normalise/round/pack) with a single global
// stall: every stage advances together whenever the output register is empty or being taken.
module fp_mult_pipe import fp_pkg::*; #(
   parameter int unsigned EXP_W    = DefExpW,
   parameter int unsigned MAN_W    = DefManW,
   parameter bit          ROUND_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   fp_mult_pipe_if.slave  bus
);

   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned SW = MAN_W + 1;
   localparam int unsigned PW = 2 * MAN_W + 2;
   localparam int unsigned EW = EXP_W + 2;

   localparam logic signed [EW-1:0] Bias    = EW'(fp_bias(EXP_W));
   localparam logic signed [EW-1:0] ExpMax  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ExpZero = '0;
   localparam logic        [W-1:0]  QNan    = W'(fp_qnan(EXP_W, MAN_W));

   logic advance;

   // S1: unpack
   logic              ua_sign, ub_sign;
   logic [EXP_W-1:0]  ua_exp, ub_exp;
   logic [SW-1:0]     ua_sig, ub_sig;
   fp_class_e         ua_cls, ub_cls;
   logic signed [EW-1:0] s1_exp_d;

   logic                 s1_valid_q;
   logic                 s1_sign_q;
   logic signed [EW-1:0] s1_exp_q;
   logic [SW-1:0]        s1_sig_a_q, s1_sig_b_q;
   fp_class_e            s1_cls_a_q, s1_cls_b_q;

   // S2: multiply
   logic [PW-1:0]        s2_prod_d;
   logic                 s2_valid_q;
   logic                 s2_sign_q;
   logic signed [EW-1:0] s2_exp_q;
   logic [PW-1:0]        s2_prod_q;
   fp_class_e            s2_cls_a_q, s2_cls_b_q;

   // S3: normalise, round, pack
   logic [PW-2:0]        norm;
   logic [MAN_W-1:0]     mant;
   logic                 guard, sticky, inc;
   logic [MAN_W:0]       mant_r;
   logic signed [EW-1:0] exp_f;
   logic                 any_nan, any_inf, any_zero;
   logic [W-1:0]         out_d;
   logic [3:0]           flags_d;

   logic                 out_valid_q;
   logic [W-1:0]         out_q;
   logic [3:0]           flags_q;

   assign advance      = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = advance;
   assign bus.out_valid = out_valid_q;
   assign bus.out      = out_q;
   assign bus.flags    = flags_q;

   fp_unpack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_unpack_a (
      .op   (bus.a),
      .sign (ua_sign),
      .bexp (ua_exp),
      .sig  (ua_sig),
      .cls  (ua_cls)
   );

   fp_unpack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_unpack_b (
      .op   (bus.b),
      .sign (ub_sign),
      .bexp (ub_exp),
      .sig  (ub_sig),
      .cls  (ub_cls)
   );

   assign s1_exp_d = $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp}) - Bias;

   assign s2_prod_d = {{SW{1'b0}}, s1_sig_a_q} * {{SW{1'b0}}, s1_sig_b_q};

   always_comb begin
      // Product lies in [1,4); align so the leading one sits just above the mantissa field.
      norm    = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
      mant    = norm[PW-2 -: MAN_W];
      guard   = norm[MAN_W];
      sticky  = |norm[MAN_W-1:0];
      inc     = ROUND_EN && guard && (sticky || mant[0]);
      mant_r  = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
      exp_f   = s2_exp_q
              + $signed({{(EW-1){1'b0}}, s2_prod_q[PW-1]})
              + $signed({{(EW-1){1'b0}}, mant_r[MAN_W]});

      any_nan  = (s2_cls_a_q == ClsNan)  || (s2_cls_b_q == ClsNan);
      any_inf  = (s2_cls_a_q == ClsInf)  || (s2_cls_b_q == ClsInf);
      any_zero = (s2_cls_a_q == ClsZero) || (s2_cls_b_q == ClsZero);

      out_d   = {s2_sign_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
      flags_d = '0;
      flags_d[FlagInexact] = guard | sticky;

      if (any_nan || (any_inf && any_zero)) begin
         out_d   = QNan;
         flags_d = '0;
         flags_d[FlagInvalid] = 1'b1;
      end else if (any_inf) begin
         out_d   = W'(fp_inf(EXP_W, MAN_W, s2_sign_q));
         flags_d = '0;
      end else if (any_zero) begin
         out_d   = {s2_sign_q, {(W-1){1'b0}}};
         flags_d = '0;
      end else if (exp_f >= ExpMax) begin
         out_d   = W'(fp_inf(EXP_W, MAN_W, s2_sign_q));
         flags_d = '0;
         flags_d[FlagOverflow] = 1'b1;
         flags_d[FlagInexact]  = 1'b1;
      end else if (exp_f <= ExpZero) begin
         out_d   = {s2_sign_q, {(W-1){1'b0}}};
         flags_d = '0;
         flags_d[FlagUnderflow] = 1'b1;
         flags_d[FlagInexact]   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_sig_a_q  <= '0;
         s1_sig_b_q  <= '0;
         s1_cls_a_q  <= ClsZero;
         s1_cls_b_q  <= ClsZero;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_exp_q    <= '0;
         s2_prod_q   <= '0;
         s2_cls_a_q  <= ClsZero;
         s2_cls_b_q  <= ClsZero;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= '0;
      end else if (advance) begin
         s1_valid_q  <= bus.in_valid;
         s1_sign_q   <= ua_sign ^ ub_sign;
         s1_exp_q    <= s1_exp_d;
         s1_sig_a_q  <= ua_sig;
         s1_sig_b_q  <= ub_sig;
         s1_cls_a_q  <= ua_cls;
         s1_cls_b_q  <= ub_cls;
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_exp_q    <= s1_exp_q;
         s2_prod_q   <= s2_prod_d;
         s2_cls_a_q  <= s1_cls_a_q;
         s2_cls_b_q  <= s1_cls_b_q;
         out_valid_q <= s2_valid_q;
         out_q       <= out_d;
         flags_q     <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: one round-to-nearest-even and one truncating instance share
// the same stimulus; results are checked against hand-computed single-precision values.
module tb_fp_mult_pipe;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_rne ();
   fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_trn ();

   assign bus_trn.in_valid  = bus_rne.in_valid;
   assign bus_trn.a         = bus_rne.a;
   assign bus_trn.b         = bus_rne.b;
   assign bus_trn.out_ready = bus_rne.out_ready;

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_EN(1'b1)) u_dut_rne (
      .clk (clk),
      .rst (rst),
      .bus (bus_rne)
   );

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_EN(1'b0)) u_dut_trn (
      .clk (clk),
      .rst (rst),
      .bus (bus_trn)
   );

   localparam int NV = 13;
   // Flags column is {invalid, overflow, underflow, inexact}.
   logic [31:0] tv_a [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'hC0000000,
                              32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000,
                              32'h80000000, 32'h7F800001, 32'h7F800000, 32'h00000001,
                              32'h80800000};
   logic [31:0] tv_b [NV] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h40400000,
                              32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000,
                              32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000,
                              32'h00800000};
   logic [31:0] tv_r [NV] = '{32'h40400000, 32'h3F800002, 32'h3FC00002, 32'hC0C00000,
                              32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                              32'h80000000};
   logic [31:0] tv_t [NV] = '{32'h40400000, 32'h3F800002, 32'h3FC00001, 32'hC0C00000,
                              32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                              32'h80000000};
   logic [3:0]  tv_f [NV] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0101, 4'b0011, 4'b1000,
                              4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0011};
   string       tv_n [NV] = '{"mul_1p5x2", "rne_tie_lo", "rne_round_up", "neg_normal",
                              "overflow", "underflow", "inf_x_zero", "neg_inf", "neg_zero",
                              "nan_in", "inf_x_inf", "subnorm_flush", "neg_underflow"};

   // Issues one operation, waits for its result and consumes it.
   task automatic apply(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] flg,
                        output logic [31:0] res_t, output logic [3:0] flg_t, output int lat);
      @(negedge clk);
      bus_rne.in_valid  = 1'b1;
      bus_rne.a         = a;
      bus_rne.b         = b;
      bus_rne.out_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus_rne.in_valid = 1'b0;
      while (!bus_rne.out_valid && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res   = bus_rne.out;
      flg   = bus_rne.flags;
      res_t = bus_trn.out;
      flg_t = bus_trn.flags;
   endtask

   task automatic test_reset();
      bus_rne.in_valid  = 1'b0;
      bus_rne.a         = '0;
      bus_rne.b         = '0;
      bus_rne.out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (bus_rne.out_valid !== 1'b0 || bus_rne.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1",
                  bus_rne.out_valid, bus_rne.in_ready);
      end
      vectors++;
      if (bus_rne.out !== 32'h0 || bus_rne.flags !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_data: out=%h flags=%b, required 00000000/0000",
                  bus_rne.out, bus_rne.flags);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [31:0] r, rt;
      logic [3:0]  f, ft;
      int          lat;
      for (int i = 0; i < NV; i++) begin
         apply(tv_a[i], tv_b[i], r, f, rt, ft, lat);
         vectors++;
         if (lat !== 3) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles, required 3", tv_n[i], lat);
         end
         vectors++;
         if (r !== tv_r[i] || f !== tv_f[i]) begin
            miscompares++;
            $display("FAIL %s_rne: got %h/%b, required %h/%b", tv_n[i], r, f, tv_r[i], tv_f[i]);
         end
         vectors++;
         if (rt !== tv_t[i] || ft !== tv_f[i]) begin
            miscompares++;
            $display("FAIL %s_trunc: got %h/%b, required %h/%b", tv_n[i], rt, ft, tv_t[i],
                     tv_f[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      int          extra = 0;
      logic        stalled = 1'b0;
      logic        in_acc, out_acc;
      logic [31:0] held;
      logic [3:0]  held_f;
      @(negedge clk);
      while (got < 8 && cyc < 300) begin
         if (stalled) begin
            vectors++;
            if (bus_rne.out_valid !== 1'b1 || bus_rne.out !== held || bus_rne.flags !== held_f)
            begin
               miscompares++;
               $display("FAIL b2b_stall_hold: got %b/%h/%b, required 1/%h/%b", bus_rne.out_valid,
                        bus_rne.out, bus_rne.flags, held, held_f);
            end
         end
         bus_rne.in_valid  = (sent < 8);
         bus_rne.a         = tv_a[sent];
         bus_rne.b         = tv_b[sent];
         bus_rne.out_ready = 1'($urandom_range(0, 1));
         #1;
         in_acc  = bus_rne.in_valid && bus_rne.in_ready;
         out_acc = bus_rne.out_valid && bus_rne.out_ready;
         if (out_acc) begin
            vectors++;
            if (bus_rne.out !== tv_r[got] || bus_rne.flags !== tv_f[got]) begin
               miscompares++;
               $display("FAIL b2b_result%0d: got %h/%b, required %h/%b", got, bus_rne.out,
                        bus_rne.flags, tv_r[got], tv_f[got]);
            end
            got++;
         end
         stalled = bus_rne.out_valid && !bus_rne.out_ready;
         held    = bus_rne.out;
         held_f  = bus_rne.flags;
         @(posedge clk);
         if (in_acc) sent++;
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (got != 8) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results, required 8", got);
      end
      bus_rne.in_valid  = 1'b0;
      bus_rne.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus_rne.out_valid) extra++;
         @(negedge clk);
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL b2b_duplicate: got %0d extra results, required 0", extra);
      end
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      @(negedge clk);
      bus_rne.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_rne.in_valid = 1'b1;
         bus_rne.a        = tv_a[i];
         bus_rne.b        = tv_b[i];
         @(posedge clk);
         @(negedge clk);
      end
      bus_rne.in_valid = 1'b0;
      vectors++;
      if (bus_rne.out_valid !== 1'b1 || bus_rne.out !== tv_r[0]) begin
         miscompares++;
         $display("FAIL flight_head: got %b/%h, required 1/%h", bus_rne.out_valid, bus_rne.out,
                  tv_r[0]);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bus_rne.out_valid !== 1'b0 || bus_rne.out !== 32'h0 || bus_rne.flags !== 4'h0) begin
         miscompares++;
         $display("FAIL flight_reset: got %b/%h/%b, required 0/00000000/0000",
                  bus_rne.out_valid, bus_rne.out, bus_rne.flags);
      end
      @(negedge clk);
      rst = 1'b0;
      bus_rne.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus_rne.in_ready !== 1'b1 || bus_rne.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flight_release: in_ready=%b out_valid=%b, required 1/0",
                  bus_rne.in_ready, bus_rne.out_valid);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (bus_rne.out_valid !== 1'b0) stale++;
      end
      vectors++;
      if (stale != 0) begin
         miscompares++;
         $display("FAIL flight_stale: got %0d stale results, required 0", stale);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule
